// File: rtl/fetch_queue_pkg.sv
// Shared types and constants for the instruction fetch queue.
// Optional same-cycle response bypass is enabled by defining FQ_BYPASS_EN.
package fetch_queue_pkg;

  localparam int unsigned FQ_ENTRY_W = 65;
  localparam logic [7:0]  ECODE_ADEF = 8'h08;

  // Queue entry layout {pc, inst, ex}
  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
    logic        ex;
  } fq_entry_t;

endpackage

// File: rtl/fq_tag_fifo.sv
// Generic synchronous FIFO with clear; when empty, dout holds the most
// recently written entry so consumers see a stable value.
module fq_tag_fifo #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned DEPTH = 2
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         push_i,
  input  logic [WIDTH-1:0]             din_i,
  input  logic                         pop_i,
  input  logic                         clear_i,
  output logic [WIDTH-1:0]             dout_o,
  output logic [$clog2(DEPTH+1)-1:0]   count_o,
  output logic                         full_o,
  output logic                         empty_o
);

  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CNT_W = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  function automatic logic [PTR_W-1:0] ptr_dec(input logic [PTR_W-1:0] p);
    return (p == '0) ? PTR_W'(DEPTH - 1) : p - 1'b1;
  endfunction

  // Clear discards contents by catching the read pointer up to the write pointer
  always_comb begin
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    cnt_d    = cnt_q;
    if (clear_i) begin
      rd_ptr_d = wr_ptr_q;
      cnt_d    = '0;
    end else begin
      if (push_i) wr_ptr_d = ptr_inc(wr_ptr_q);
      if (pop_i)  rd_ptr_d = ptr_inc(rd_ptr_q);
      cnt_d = cnt_q + CNT_W'(push_i) - CNT_W'(pop_i);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      cnt_q    <= '0;
      for (int i = 0; i < int'(DEPTH); i++) mem_q[i] <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      cnt_q    <= cnt_d;
      if (push_i && !clear_i) mem_q[wr_ptr_q] <= din_i;
    end
  end

  assign dout_o  = (cnt_q == '0) ? mem_q[ptr_dec(rd_ptr_q)] : mem_q[rd_ptr_q];
  assign count_o = cnt_q;
  assign full_o  = (cnt_q == CNT_W'(DEPTH));
  assign empty_o = (cnt_q == '0);

endmodule

// File: rtl/fetch_queue.sv
// Instruction fetch front end: sequential PC requests with several in flight,
// stale-response dropping after redirect, and a buffered queue to pre-decode.
module fetch_queue
  import fetch_queue_pkg::*;
#(
  parameter int unsigned DEPTH    = 4,
  parameter int unsigned MAX_OUT  = 2,
  parameter logic [31:0] RESET_PC = 32'h1c00_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        inst_sram_req,
  output logic [31:0] inst_sram_addr,
  input  logic        inst_sram_addr_ok,
  input  logic        inst_sram_data_ok,
  input  logic [31:0] inst_sram_rdata,
  output logic        FpD_valid,
  input  logic        pD_allowin,
  output logic [31:0] FpD_pc,
  output logic [31:0] FpD_inst,
  output logic        FpD_ex,
  output logic [7:0]  FpD_ecode
);

  localparam int unsigned OUT_W = $clog2(MAX_OUT + 1);
  localparam int unsigned Q_W   = $clog2(DEPTH + 1);
  localparam int unsigned OCC_W = Q_W + 1;

  logic [31:0]      fetch_pc_q, fetch_pc_d, addr_q, addr_d;
  logic             req_q, req_d, halted_q, halted_d, stale_q, stale_d;
  logic [OUT_W-1:0] drop_q, drop_d;

  logic [OUT_W-1:0] out_cnt, out_cnt_d, live_d;
  logic [Q_W-1:0]   q_cnt, q_cnt_d;
  logic [31:0]      tag_pc;
  logic             tag_full, tag_empty, q_full, q_empty;
  logic             accept, rsp_live, adef_push, hold, byp_take, q_push, q_pop;
  fq_entry_t        q_din, q_dout;

  fq_tag_fifo #(.WIDTH(32), .DEPTH(MAX_OUT)) u_tag_fifo (
    .clk(clk), .rst(rst),
    .push_i(accept), .din_i(addr_q), .pop_i(inst_sram_data_ok), .clear_i(1'b0),
    .dout_o(tag_pc), .count_o(out_cnt), .full_o(tag_full), .empty_o(tag_empty)
  );

  fq_tag_fifo #(.WIDTH(FQ_ENTRY_W), .DEPTH(DEPTH)) u_inst_queue (
    .clk(clk), .rst(rst),
    .push_i(q_push), .din_i(q_din), .pop_i(q_pop), .clear_i(redirect_valid),
    .dout_o(q_dout), .count_o(q_cnt), .full_o(q_full), .empty_o(q_empty)
  );

  // stale_q marks a request held across a redirect; it is dropped once accepted
  always_comb begin
    accept    = req_q && inst_sram_addr_ok;
    hold      = req_q && !inst_sram_addr_ok;
    rsp_live  = inst_sram_data_ok && (drop_q == '0);
    adef_push = (fetch_pc_q[1:0] != 2'b00) && !halted_q && (out_cnt == drop_q) && !q_full;
    byp_take  = 1'b0;
`ifdef FQ_BYPASS_EN
    byp_take  = rsp_live && q_empty && pD_allowin && !redirect_valid;
`endif
    q_pop     = !q_empty && pD_allowin;
    q_push    = !redirect_valid && ((rsp_live && !byp_take) || adef_push);
    q_din.pc   = adef_push ? fetch_pc_q : tag_pc;
    q_din.inst = adef_push ? 32'h0 : inst_sram_rdata;
    q_din.ex   = adef_push;

    out_cnt_d = out_cnt + OUT_W'(accept) - OUT_W'(inst_sram_data_ok);
    q_cnt_d   = redirect_valid ? '0 : q_cnt + Q_W'(q_push) - Q_W'(q_pop);
    drop_d     = drop_q;
    stale_d    = stale_q;
    fetch_pc_d = fetch_pc_q;
    halted_d   = halted_q;
    if (redirect_valid) begin
      drop_d     = out_cnt_d;
      stale_d    = hold;
      fetch_pc_d = redirect_pc;
      halted_d   = 1'b0;
    end else begin
      drop_d     = drop_q - OUT_W'(inst_sram_data_ok && (drop_q != '0)) + OUT_W'(accept && stale_q);
      stale_d    = stale_q && !accept;
      fetch_pc_d = (accept && !stale_q) ? fetch_pc_q + 32'd4 : fetch_pc_q;
      halted_d   = halted_q || adef_push;
    end

    // Credits evaluated on next-state counts so req can be a plain register
    live_d = out_cnt_d - drop_d;
    req_d  = hold || (!halted_d && (fetch_pc_d[1:0] == 2'b00) &&
                      (out_cnt_d < OUT_W'(MAX_OUT)) &&
                      ((OCC_W'(live_d) + OCC_W'(q_cnt_d)) < OCC_W'(DEPTH)));
    addr_d = hold ? addr_q : fetch_pc_d;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fetch_pc_q <= RESET_PC;
      addr_q     <= RESET_PC;
      req_q      <= 1'b0;
      drop_q     <= '0;
      halted_q   <= 1'b0;
      stale_q    <= 1'b0;
    end else begin
      fetch_pc_q <= fetch_pc_d;
      addr_q     <= addr_d;
      req_q      <= req_d;
      drop_q     <= drop_d;
      halted_q   <= halted_d;
      stale_q    <= stale_d;
    end
  end

  assign inst_sram_req  = req_q;
  assign inst_sram_addr = addr_q;

`ifdef FQ_BYPASS_EN
  logic byp_show;
  assign byp_show  = rsp_live && q_empty && !redirect_valid;
  assign FpD_valid = !q_empty || byp_show;
  assign FpD_pc    = byp_show ? tag_pc : q_dout.pc;
  assign FpD_inst  = byp_show ? inst_sram_rdata : q_dout.inst;
  assign FpD_ex    = byp_show ? 1'b0 : q_dout.ex;
`else
  assign FpD_valid = !q_empty;
  assign FpD_pc    = q_dout.pc;
  assign FpD_inst  = q_dout.inst;
  assign FpD_ex    = q_dout.ex;
`endif
  assign FpD_ecode = FpD_ex ? ECODE_ADEF : 8'h00;

  a_no_orphan_rsp: assert property (@(posedge clk) disable iff (rst)
    !(inst_sram_data_ok && tag_empty));
  a_counts: assert property (@(posedge clk) disable iff (rst)
    (out_cnt <= OUT_W'(MAX_OUT)) && (drop_q <= out_cnt));
  a_tag_ovf: assert property (@(posedge clk) disable iff (rst)
    !(accept && tag_full && !inst_sram_data_ok));
  a_q_ovf: assert property (@(posedge clk) disable iff (rst)
    !(q_push && q_full && !q_pop));

endmodule

// File: tb/tb_fetch_queue.sv
// Directed bench for fetch_queue: streaming, backpressure, stale drop,
// held request across redirect, ADEF and asynchronous reset.
module tb_fetch_queue;

  logic        clk, rst, redirect_valid;
  logic [31:0] redirect_pc;
  logic        inst_sram_req, inst_sram_addr_ok, inst_sram_data_ok;
  logic [31:0] inst_sram_addr, inst_sram_rdata;
  logic        FpD_valid, pD_allowin, FpD_ex;
  logic [31:0] FpD_pc, FpD_inst;
  logic [7:0]  FpD_ecode;

  int          n_assert = 0;
  int          n_fail   = 0;
  logic        rsp_en;
  logic [31:0] pend_q [$];

  fetch_queue #(.DEPTH(4), .MAX_OUT(2), .RESET_PC(32'h1c00_0000)) dut (
    .clk(clk), .rst(rst),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .inst_sram_req(inst_sram_req), .inst_sram_addr(inst_sram_addr),
    .inst_sram_addr_ok(inst_sram_addr_ok), .inst_sram_data_ok(inst_sram_data_ok),
    .inst_sram_rdata(inst_sram_rdata),
    .FpD_valid(FpD_valid), .pD_allowin(pD_allowin), .FpD_pc(FpD_pc),
    .FpD_inst(FpD_inst), .FpD_ex(FpD_ex), .FpD_ecode(FpD_ecode)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // In-order memory model: answers one cycle after acceptance, data = ~addr
  always @(negedge clk) begin : responder
    logic [31:0] a;
    if (rst) begin
      pend_q.delete();
      inst_sram_data_ok = 1'b0;
      inst_sram_rdata   = 32'h0;
    end else begin
      if (rsp_en && pend_q.size() > 0) begin
        a = pend_q.pop_front();
        inst_sram_rdata   = ~a;
        inst_sram_data_ok = 1'b1;
      end else begin
        inst_sram_data_ok = 1'b0;
      end
      if (inst_sram_req && inst_sram_addr_ok) pend_q.push_back(inst_sram_addr);
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic wait_valid(input string tag, input int max_cyc);
    int k;
    k = 0;
    while (!FpD_valid && k < max_cyc) begin
      step();
      k++;
    end
    check(tag, 32'(FpD_valid), 32'd1);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    redirect_valid = 1'b0;
    step();
    step();
    rst = 1'b0;
  endtask

  initial begin
    logic [31:0] exp_pc;
    rst = 1'b1; redirect_valid = 1'b0; redirect_pc = 32'h0;
    inst_sram_addr_ok = 1'b0; pD_allowin = 1'b0; rsp_en = 1'b0;

    // Reset state
    step();
    check("rst_req",   32'(inst_sram_req), 32'd0);
    check("rst_addr",  inst_sram_addr, 32'h1c00_0000);
    check("rst_valid", 32'(FpD_valid), 32'd0);
    check("rst_ex",    32'(FpD_ex), 32'd0);
    check("rst_ecode", 32'(FpD_ecode), 32'd0);

    // Streaming with no bubbles
    do_reset();
    inst_sram_addr_ok = 1'b1; rsp_en = 1'b1; pD_allowin = 1'b1;
    wait_valid("stream_first", 20);
    for (int i = 0; i < 6; i++) begin
      exp_pc = 32'h1c00_0000 + 32'(4 * i);
      check("stream_valid", 32'(FpD_valid), 32'd1);
      check("stream_pc", FpD_pc, exp_pc);
      check("stream_inst", FpD_inst, ~exp_pc);
      step();
    end

    // Backpressure: queue fills to 4 and fetch stops
    do_reset();
    pD_allowin = 1'b0;
    for (int i = 0; i < 15; i++) step();
    check("bp_req_off", 32'(inst_sram_req), 32'd0);
    check("bp_valid", 32'(FpD_valid), 32'd1);
    pD_allowin = 1'b1;
    for (int i = 0; i < 4; i++) begin
      check("bp_pop_pc", FpD_pc, 32'h1c00_0000 + 32'(4 * i));
      if (i == 1) begin
        check("bp_resume_req", 32'(inst_sram_req), 32'd1);
        check("bp_resume_addr", inst_sram_addr, 32'h1c00_0010);
      end
      step();
    end
    check("bp_next_pc", FpD_pc, 32'h1c00_0010);

    // Stale drop: two outstanding discarded after redirect
    do_reset();
    rsp_en = 1'b0;
    for (int i = 0; i < 4; i++) step();
    check("stale_req_off", 32'(inst_sram_req), 32'd0);
    check("stale_valid0", 32'(FpD_valid), 32'd0);
    redirect_valid = 1'b1; redirect_pc = 32'h1c00_0100;
    step();
    redirect_valid = 1'b0;
    check("stale_req_wait", 32'(inst_sram_req), 32'd0);
    rsp_en = 1'b1;
    wait_valid("stale_first", 20);
    check("stale_pc", FpD_pc, 32'h1c00_0100);
    check("stale_inst", FpD_inst, ~32'h1c00_0100);

    // Held request across redirect
    inst_sram_addr_ok = 1'b0;
    do_reset();
    step();
    step();
    check("hold_req", 32'(inst_sram_req), 32'd1);
    check("hold_addr", inst_sram_addr, 32'h1c00_0000);
    redirect_valid = 1'b1; redirect_pc = 32'h1c00_0200;
    step();
    redirect_valid = 1'b0;
    check("hold_req_kept", 32'(inst_sram_req), 32'd1);
    check("hold_addr_kept", inst_sram_addr, 32'h1c00_0000);
    inst_sram_addr_ok = 1'b1;
    step();
    check("hold_next_req", 32'(inst_sram_req), 32'd1);
    check("hold_next_addr", inst_sram_addr, 32'h1c00_0200);
    wait_valid("hold_first", 20);
    check("hold_pc", FpD_pc, 32'h1c00_0200);

    // ADEF on misaligned redirect
    pD_allowin = 1'b0;
    do_reset();
    redirect_valid = 1'b1; redirect_pc = 32'h1c00_0102;
    step();
    redirect_valid = 1'b0;
    check("adef_no_req", 32'(inst_sram_req), 32'd0);
    step();
    check("adef_valid", 32'(FpD_valid), 32'd1);
    check("adef_pc", FpD_pc, 32'h1c00_0102);
    check("adef_ex", 32'(FpD_ex), 32'd1);
    check("adef_ecode", 32'(FpD_ecode), 32'h08);
    check("adef_inst", FpD_inst, 32'h0);
    pD_allowin = 1'b1;
    for (int i = 0; i < 4; i++) step();
    check("adef_silent_valid", 32'(FpD_valid), 32'd0);
    check("adef_silent_req", 32'(inst_sram_req), 32'd0);
    redirect_valid = 1'b1; redirect_pc = 32'h1c00_0300;
    step();
    redirect_valid = 1'b0;
    check("adef_resume_req", 32'(inst_sram_req), 32'd1);
    check("adef_resume_addr", inst_sram_addr, 32'h1c00_0300);
    wait_valid("adef_resume_first", 20);
    check("adef_resume_pc", FpD_pc, 32'h1c00_0300);
    check("adef_resume_ex", 32'(FpD_ex), 32'd0);
    check("adef_resume_ecode", 32'(FpD_ecode), 32'd0);

    // Asynchronous reset mid-stream
    do_reset();
    for (int i = 0; i < 6; i++) step();
    check("ar_pre_req", 32'(inst_sram_req), 32'd1);
    check("ar_pre_valid", 32'(FpD_valid), 32'd1);
    #2 rst = 1'b1;
    #1;
    check("ar_req", 32'(inst_sram_req), 32'd0);
    check("ar_valid", 32'(FpD_valid), 32'd0);
    check("ar_addr", inst_sram_addr, 32'h1c00_0000);
    step();
    rst = 1'b0;
    step();
    check("ar_post_req", 32'(inst_sram_req), 32'd1);
    check("ar_post_addr", inst_sram_addr, 32'h1c00_0000);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
